pzbcm_rle_expander: RTL and testbench



---
 rtl/pzbcm_rle_pkg.sv | 26 ++
 rtl/pzbcm_rle_expander_skid.sv | 43 ++++
 rtl/pzbcm_rle_expander.sv | 99 +++++++++
 tb/tb_pzbcm_rle_expander.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pzbcm_rle_pkg.sv
// Shared types and helpers for the run-length expander.
package pzbcm_rle_pkg;

  // Expander state: IDLE holds no beat, EXPAND presents a beat on o_valid.
  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } pzbcm_rle_expander_state;

  // Widest repeat counter the helper below supports.
  localparam int unsigned REMAINING_MAX_WIDTH = 32;

  // Copies left after a beat pops; saturates at zero so it can never wrap.
  function automatic logic [REMAINING_MAX_WIDTH-1:0] next_remaining(
    input logic [REMAINING_MAX_WIDTH-1:0] remaining,
    input logic                           pop
  );
    logic [REMAINING_MAX_WIDTH-1:0] result;
    result = remaining;
    if (pop && (remaining != '0)) begin
      result = remaining - REMAINING_MAX_WIDTH'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/pzbcm_rle_expander_skid.sv
// Generic one-entry valid/ready skid register.
// The upstream ready is a flop output with no combinational path from i_ready.
module pzbcm_rle_expander_skid
  import pzbcm_rle_pkg::*;
#(
  parameter type TYPE = logic
)(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_valid,
  output logic o_ready,
  input  TYPE  i_data,
  output logic o_valid,
  input  logic i_ready,
  output TYPE  o_data
);

  logic skid_valid;
  TYPE  skid_data;

  // Park an incoming entry the downstream cannot take; release it once taken.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (i_clear) begin
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (i_ready) begin
        skid_valid <= 1'b0;
      end
    end else if (i_valid && !i_ready) begin
      skid_valid <= 1'b1;
      skid_data  <= i_data;
    end
  end

  assign o_ready = !skid_valid;
  assign o_valid = skid_valid || i_valid;
  assign o_data  = skid_valid ? skid_data : i_data;

endmodule

// File: rtl/pzbcm_rle_expander.sv
// Run-length expander: each {data, count} entry becomes count beats of data.
// Build option PZBCM_RLE_EXPANDER_SKID_EN inserts a one-entry input skid
// register so o_ready is a flop output; otherwise o_ready is combinational
// from i_ready.
module pzbcm_rle_expander
  import pzbcm_rle_pkg::*;
#(
  parameter type         TYPE        = logic,
  parameter int unsigned COUNT_WIDTH = 4
)(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  TYPE                    i_data,
  input  logic [COUNT_WIDTH-1:0] i_count,
  output logic                   o_valid,
  input  logic                   i_ready,
  output TYPE                    o_data,
  output logic                   o_last,
  output logic [COUNT_WIDTH-1:0] o_remaining
);

  typedef logic [COUNT_WIDTH-1:0] COUNTER;

  typedef struct packed {
    TYPE    data;
    COUNTER count;
  } entry_t;

  pzbcm_rle_expander_state state;
  TYPE                     data_q;
  COUNTER                  remaining_q;

  entry_t in_entry;
  entry_t entry;
  logic   entry_valid;
  logic   entry_ready;
  logic   entry_load;
  logic   beat_accept;
  logic   beat_last;

  assign in_entry = '{data: i_data, count: i_count};

  assign o_valid     = (state == EXPAND);
  assign beat_last   = (remaining_q == '0);
  assign o_last      = o_valid && beat_last;
  assign o_data      = data_q;
  assign o_remaining = remaining_q;

  // Zero-bubble handoff: the last-beat accept frees the slot in the same cycle.
  assign beat_accept = o_valid && i_ready;
  assign entry_ready = (state == IDLE) || (beat_accept && beat_last);
  // A zero-count entry is consumed without loading anything.
  assign entry_load  = entry_valid && entry_ready && (entry.count != '0);

`ifdef PZBCM_RLE_EXPANDER_SKID_EN
  pzbcm_rle_expander_skid #(
    .TYPE (entry_t)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (i_clear),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (in_entry),
    .o_valid (entry_valid),
    .i_ready (entry_ready),
    .o_data  (entry)
  );
`else
  assign entry_valid = i_valid;
  assign entry       = in_entry;
  assign o_ready     = entry_ready;
`endif

  // Expansion state machine and repeat counter; clear wins over any accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      data_q      <= '0;
      remaining_q <= '0;
    end else if (i_clear) begin
      state       <= IDLE;
      remaining_q <= '0;
    end else if (entry_load) begin
      state       <= EXPAND;
      data_q      <= entry.data;
      remaining_q <= entry.count - COUNTER'(1);
    end else if (beat_accept) begin
      if (beat_last) begin
        state <= IDLE;
      end
      remaining_q <= COUNTER'(next_remaining(REMAINING_MAX_WIDTH'(remaining_q), 1'b1));
    end
  end

endmodule

// File: tb/tb_pzbcm_rle_expander.sv
// Self-checking bench for pzbcm_rle_expander (directed steps plus random traffic
// against a beat-queue model of the expected uncompressed stream).
`timescale 1ns/1ps
module tb_pzbcm_rle_expander;

  localparam int unsigned CW = 4;
  typedef logic [7:0]    data_t;
  typedef logic [CW-1:0] cnt_t;

  typedef struct {
    data_t d;
    cnt_t  c;
  } ent_t;

  typedef struct {
    data_t d;
    cnt_t  r;
    logic  l;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst, clr, iv, ordy, ov, ir, ol;
  data_t id, od;
  cnt_t  ic, orem;

  always #5 clk = ~clk;

  pzbcm_rle_expander #(
    .TYPE        (data_t),
    .COUNT_WIDTH (CW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_clear     (clr),
    .i_valid     (iv),
    .o_ready     (ordy),
    .i_data      (id),
    .i_count     (ic),
    .o_valid     (ov),
    .i_ready     (ir),
    .o_data      (od),
    .o_last      (ol),
    .o_remaining (orem)
  );

  int checks = 0;
  int errors = 0;

  ent_t  src_q[$];
  beat_t exp_q[$];
  logic  sb_on = 1'b0;
  logic  prev_stall = 1'b0;
  data_t prev_d = '0;
  cnt_t  prev_r = '0;
  int    n_beats = 0;

  logic  s_valid, s_last, s_ready, s_iready, s_iacc, s_oacc;
  data_t s_data;
  cnt_t  s_rem;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expected);
    checks++;
    assert (obs === expected) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expected);
    end
  endtask

  // One clock: sample at the falling edge, then advance the source driver.
  task automatic step();
    logic r0;
    @(negedge clk);
`ifdef PZBCM_RLE_EXPANDER_SKID_EN
    r0 = ordy;
    ir = ~ir;
    #1;
    check("ready_indep_of_i_ready", 32'(ordy), 32'(r0));
    ir = ~ir;
    #1;
`else
    r0 = 1'b0;
`endif
    s_valid  = ov;
    s_data   = od;
    s_rem    = orem;
    s_last   = ol;
    s_ready  = ordy;
    s_iready = ir;
    s_iacc   = iv && ordy;
    s_oacc   = ov && ir;
    if (s_oacc) n_beats++;
    if (sb_on) begin
      if (prev_stall) begin
        check("stall_valid", 32'(s_valid), 32'(1'b1));
        check("stall_data", 32'(s_data), 32'(prev_d));
        check("stall_rem", 32'(s_rem), 32'(prev_r));
      end
`ifndef PZBCM_RLE_EXPANDER_SKID_EN
      check("ready_rule", 32'(s_ready), 32'(!s_valid || (s_last && s_iready)));
`endif
      if (s_oacc) begin
        if (exp_q.size() == 0) begin
          check("beat_without_entry", 32'(exp_q.size()), 32'(1));
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          check("rnd_data", 32'(s_data), 32'(b.d));
          check("rnd_rem", 32'(s_rem), 32'(b.r));
          check("rnd_last", 32'(s_last), 32'(b.l));
        end
      end
      if (s_iacc) begin
        for (int k = int'(ic); k >= 1; k--) begin
          beat_t nb;
          nb.d = id;
          nb.r = cnt_t'(k - 1);
          nb.l = (k == 1);
          exp_q.push_back(nb);
        end
      end
      prev_stall = s_valid && !s_iready;
      prev_d     = s_data;
      prev_r     = s_rem;
    end
    @(posedge clk);
    #1;
    if (s_iacc || !iv) begin
      if (src_q.size() > 0) begin
        ent_t e;
        e  = src_q.pop_front();
        iv = 1'b1;
        id = e.d;
        ic = e.c;
      end else begin
        iv = 1'b0;
      end
    end
  endtask

  // Compare the last sampled beat; data/remaining are don't-care when idle.
  task automatic exp_beat(input string tag, input logic v, input data_t d, input cnt_t r, input logic l);
    check({tag, "_valid"}, 32'(s_valid), 32'(v));
    if (v) begin
      check({tag, "_data"}, 32'(s_data), 32'(d));
      check({tag, "_rem"}, 32'(s_rem), 32'(r));
    end
    check({tag, "_last"}, 32'(s_last), 32'(l));
  endtask

  task automatic push(input data_t d, input cnt_t c);
    ent_t e;
    e.d = d;
    e.c = c;
    src_q.push_back(e);
  endtask

  initial begin
    int base;
    logic done;
    rst = 1'b1; clr = 1'b0; iv = 1'b0; ir = 1'b1; id = '0; ic = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    step();
    exp_beat("reset", 1'b0, 8'h00, '0, 1'b0);
    check("reset_rem", 32'(s_rem), 32'(0));
    check("reset_ready", 32'(s_ready), 32'(1'b1));

    // Single entry {A5,3}
    push(8'hA5, 4'd3);
    step();
    step(); exp_beat("t1_idle", 1'b0, 8'h00, '0, 1'b0);
    check("t1_accept", 32'(s_iacc), 32'(1'b1));
    step(); exp_beat("t1_b0", 1'b1, 8'hA5, 4'd2, 1'b0);
    step(); exp_beat("t1_b1", 1'b1, 8'hA5, 4'd1, 1'b0);
    step(); exp_beat("t1_b2", 1'b1, 8'hA5, 4'd0, 1'b1);
    step(); exp_beat("t1_end", 1'b0, 8'h00, '0, 1'b0);

    // Back-to-back {11,1},{22,2},{33,1}
    push(8'h11, 4'd1); push(8'h22, 4'd2); push(8'h33, 4'd1);
    step();
    step(); exp_beat("t2_idle", 1'b0, 8'h00, '0, 1'b0);
    step(); exp_beat("t2_b11", 1'b1, 8'h11, 4'd0, 1'b1);
    step(); exp_beat("t2_b22a", 1'b1, 8'h22, 4'd1, 1'b0);
    step(); exp_beat("t2_b22b", 1'b1, 8'h22, 4'd0, 1'b1);
    step(); exp_beat("t2_b33", 1'b1, 8'h33, 4'd0, 1'b1);
    step(); exp_beat("t2_end", 1'b0, 8'h00, '0, 1'b0);

    // {7E,2} with a 5-cycle consumer stall
    push(8'h7E, 4'd2);
    base = n_beats;
    step();
    step();
    ir = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); exp_beat("t3_stall", 1'b1, 8'h7E, 4'd1, 1'b0);
    end
    ir = 1'b1;
    step(); exp_beat("t3_b0", 1'b1, 8'h7E, 4'd1, 1'b0);
    step(); exp_beat("t3_b1", 1'b1, 8'h7E, 4'd0, 1'b1);
    step(); exp_beat("t3_end", 1'b0, 8'h00, '0, 1'b0);
    check("t3_beat_count", 32'(n_beats - base), 32'(2));

    // Zero-count entry between two singles
    push(8'h01, 4'd1); push(8'hC3, 4'd0); push(8'h02, 4'd1);
    base = n_beats;
    step();
    step();
    step(); exp_beat("t4_b01", 1'b1, 8'h01, 4'd0, 1'b1);
    check("t4_zero_consumed", 32'(s_iacc), 32'(1'b1));
    step(); exp_beat("t4_gap", 1'b0, 8'h00, '0, 1'b0);
    step(); exp_beat("t4_b02", 1'b1, 8'h02, 4'd0, 1'b1);
    step(); exp_beat("t4_end", 1'b0, 8'h00, '0, 1'b0);
    check("t4_beat_count", 32'(n_beats - base), 32'(2));

    // Synchronous clear mid-run of {55,15}
    push(8'h55, 4'd15);
    step();
    step();
    step(); exp_beat("t5_b0", 1'b1, 8'h55, 4'd14, 1'b0);
    step(); exp_beat("t5_b1", 1'b1, 8'h55, 4'd13, 1'b0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    push(8'h66, 4'd1);
    step(); exp_beat("t5_cleared", 1'b0, 8'h00, '0, 1'b0);
    check("t5_ready", 32'(s_ready), 32'(1'b1));
    check("t5_rem", 32'(s_rem), 32'(0));
    step();
    step(); exp_beat("t5_b66", 1'b1, 8'h66, 4'd0, 1'b1);
    step(); exp_beat("t5_end", 1'b0, 8'h00, '0, 1'b0);

    // Asynchronous reset mid-run of {55,15}
    push(8'h55, 4'd15);
    step();
    step();
    step(); exp_beat("t6_b0", 1'b1, 8'h55, 4'd14, 1'b0);
    step(); exp_beat("t6_b1", 1'b1, 8'h55, 4'd13, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("t6_async_valid", 32'(ov), 32'(1'b0));
    check("t6_async_ready", 32'(ordy), 32'(1'b1));
    check("t6_async_rem", 32'(orem), 32'(0));
    @(negedge clk);
    #1 rst = 1'b0;
    push(8'h66, 4'd1);
    step(); exp_beat("t6_idle", 1'b0, 8'h00, '0, 1'b0);
    step();
    step(); exp_beat("t6_b66", 1'b1, 8'h66, 4'd0, 1'b1);
    step(); exp_beat("t6_end", 1'b0, 8'h00, '0, 1'b0);

    // Random traffic against the beat-queue model
    exp_q.delete();
    prev_stall = 1'b0;
    sb_on = 1'b1;
    for (int i = 0; i < 800; i++) begin
      ir = ($urandom_range(0, 3) != 0);
      if (src_q.size() == 0 && $urandom_range(0, 2) != 0) begin
        push(data_t'($urandom_range(0, 255)), cnt_t'($urandom_range(0, 15)));
      end
      step();
    end
    ir = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      step();
      done = (src_q.size() == 0) && !iv && (exp_q.size() == 0) && !ov;
    end
    check("drain_done", 32'(done), 32'(1'b1));
    check("drain_exp_left", 32'(exp_q.size()), 32'(0));
    sb_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
